// File: rtl/render_pkg.sv
`default_nettype none
// ============================================================================
// Module      : render_pkg
// Description : Shared definitions for the render pipeline. It holds the
//               default geometry sizes, the index widths derived from them,
//               the 4-bit colour codes and the scene_culler state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package render_pkg;

  localparam int WORLD_BITS_DEF  = 32;
  localparam int MAX_VERTS_DEF   = 8;
  localparam int MAX_POLYS_DEF   = 4;
  localparam int WORLD_POLYS_DEF = 16;

  localparam int VERT_IDX_W  = $clog2(MAX_VERTS_DEF);
  localparam int SIDES_W     = $clog2(MAX_VERTS_DEF + 1);
  localparam int SLOT_IDX_W  = $clog2(MAX_POLYS_DEF);
  localparam int COUNT_W     = $clog2(MAX_POLYS_DEF + 1);
  localparam int POLY_IDX_W  = $clog2(WORLD_POLYS_DEF);

  typedef enum logic [3:0] {
    BLACK   = 4'd0,
    WHITE   = 4'd1,
    RED     = 4'd2,
    GREEN   = 4'd3,
    BLUE    = 4'd4,
    YELLOW  = 4'd5,
    CYAN    = 4'd6,
    MAGENTA = 4'd7,
    ORANGE  = 4'd8,
    PURPLE  = 4'd9,
    BROWN   = 4'd10,
    PINK    = 4'd11,
    GRAY    = 4'd12,
    LGRAY   = 4'd13,
    DBLUE   = 4'd14,
    LBLUE   = 4'd15
  } color_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_CHECK = 3'd2,
    S_NEXT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/bbox_accum.sv
`default_nettype none
// ============================================================================
// Module      : bbox_accum
// Description : Running signed minimum / maximum over a stream of values.
//               i_clear re-arms the tracker (min = most positive, max = most
//               negative) so the first enabled value becomes both extremes.
// Ports       : clk_in, rst_in     clock, asynchronous active-high reset
//               i_clear            re-arm the tracker (has priority)
//               i_en               fold i_val into the running extremes
//               i_val              signed sample
//               o_min, o_max       running extremes
// Revision    : 1.0 - initial release
// ============================================================================
module bbox_accum
  import render_pkg::*;
#(
  parameter int WORLD_BITS = WORLD_BITS_DEF
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         i_clear,
  input  logic                         i_en,
  input  logic signed [WORLD_BITS-1:0] i_val,
  output logic signed [WORLD_BITS-1:0] o_min,
  output logic signed [WORLD_BITS-1:0] o_max
);

  localparam logic signed [WORLD_BITS-1:0] c_POS_MAX = {1'b0, {(WORLD_BITS-1){1'b1}}};
  localparam logic signed [WORLD_BITS-1:0] c_NEG_MIN = {1'b1, {(WORLD_BITS-1){1'b0}}};

  logic signed [WORLD_BITS-1:0] r_min;
  logic signed [WORLD_BITS-1:0] r_max;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_min <= c_POS_MAX;
      r_max <= c_NEG_MIN;
    end else if (i_clear) begin
      r_min <= c_POS_MAX;
      r_max <= c_NEG_MIN;
    end else if (i_en) begin
      if (i_val < r_min) r_min <= i_val;
      if (i_val > r_max) r_max <= i_val;
    end
  end

  assign o_min = r_min;
  assign o_max = r_max;

endmodule
`default_nettype wire

// File: rtl/scene_culler.sv
`default_nettype none
// ============================================================================
// Module      : scene_culler
// Description : Once per frame scans the world polygon store and keeps the
//               polygons whose bounding box meets the camera window (grown by
//               CULL_MARGIN). Results are built in a working buffer and are
//               copied to the published outputs only at new_frame_in.
// Ports       : clk_in/rst_in          clock, asynchronous active-high reset
//               new_frame_in           frame pulse; publishes and restarts
//               camera_*_in            camera centre sampled at new_frame_in
//               world_poly/vert_out    world store read address
//               world_*_in             store data, one cycle after address
//               camera_*_out, polygons_*_out, colors_out, num_polygons_out,
//               overflow_out           published on-screen set
//               overrun_out            sticky: frame arrived mid-scan
//               busy_out               scan in progress
// Revision    : 1.0 - initial release
// ============================================================================
module scene_culler
  import render_pkg::*;
#(
  parameter int PIXEL_WIDTH            = 1280,
  parameter int PIXEL_HEIGHT           = 720,
  parameter int WORLD_BITS             = WORLD_BITS_DEF,
  parameter int MAX_NUM_VERTICES       = MAX_VERTS_DEF,
  parameter int MAX_POLYGONS_ON_SCREEN = MAX_POLYS_DEF,
  parameter int NUM_WORLD_POLYGONS     = WORLD_POLYS_DEF,
  parameter int CULL_MARGIN            = 16,
  localparam int VW  = $clog2(MAX_NUM_VERTICES),
  localparam int SW  = $clog2(MAX_NUM_VERTICES + 1),
  localparam int PW  = $clog2(NUM_WORLD_POLYGONS),
  localparam int CW  = $clog2(MAX_POLYGONS_ON_SCREEN + 1)
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         new_frame_in,
  input  logic signed [WORLD_BITS-1:0] camera_x_in,
  input  logic signed [WORLD_BITS-1:0] camera_y_in,
  output logic [PW-1:0]                world_poly_out,
  output logic [VW-1:0]                world_vert_out,
  input  logic signed [WORLD_BITS-1:0] world_x_in,
  input  logic signed [WORLD_BITS-1:0] world_y_in,
  input  logic [SW-1:0]                world_sides_in,
  input  logic [3:0]                   world_color_in,
  output logic signed [WORLD_BITS-1:0] camera_x_out,
  output logic signed [WORLD_BITS-1:0] camera_y_out,
  output logic signed [WORLD_BITS-1:0] polygons_xs_out [MAX_POLYGONS_ON_SCREEN][MAX_NUM_VERTICES],
  output logic signed [WORLD_BITS-1:0] polygons_ys_out [MAX_POLYGONS_ON_SCREEN][MAX_NUM_VERTICES],
  output logic [SW-1:0]                polygons_num_sides_out [MAX_POLYGONS_ON_SCREEN],
  output logic [3:0]                   colors_out [MAX_POLYGONS_ON_SCREEN],
  output logic [CW-1:0]                num_polygons_out,
  output logic                         overflow_out,
  output logic                         overrun_out,
  output logic                         busy_out
);

  localparam int SLW = (MAX_POLYGONS_ON_SCREEN > 1) ? $clog2(MAX_POLYGONS_ON_SCREEN) : 1;
  localparam logic [SW-1:0] c_LAST_VERT = SW'(MAX_NUM_VERTICES);
  localparam logic [PW-1:0] c_LAST_POLY = PW'(NUM_WORLD_POLYGONS - 1);
  localparam logic [CW-1:0] c_SLOTS     = CW'(MAX_POLYGONS_ON_SCREEN);
  localparam logic signed [WORLD_BITS:0] c_XREACH = (WORLD_BITS+1)'(PIXEL_WIDTH/2  + CULL_MARGIN);
  localparam logic signed [WORLD_BITS:0] c_YREACH = (WORLD_BITS+1)'(PIXEL_HEIGHT/2 + CULL_MARGIN);

  state_t r_state, w_next;
  logic   w_busy;

  logic [PW-1:0] r_poly;
  logic [SW-1:0] r_vert;   // counts one past the last address to catch the final return
  logic signed [WORLD_BITS-1:0] r_cam_x, r_cam_y;

  // Working buffer
  logic signed [WORLD_BITS-1:0] r_wxs [MAX_POLYGONS_ON_SCREEN][MAX_NUM_VERTICES];
  logic signed [WORLD_BITS-1:0] r_wys [MAX_POLYGONS_ON_SCREEN][MAX_NUM_VERTICES];
  logic [SW-1:0]                r_wsides [MAX_POLYGONS_ON_SCREEN];
  logic [3:0]                   r_wcolors [MAX_POLYGONS_ON_SCREEN];
  logic [CW-1:0]                r_wcount;
  logic                         r_wovf;

  // Published buffer
  logic signed [WORLD_BITS-1:0] r_pxs [MAX_POLYGONS_ON_SCREEN][MAX_NUM_VERTICES];
  logic signed [WORLD_BITS-1:0] r_pys [MAX_POLYGONS_ON_SCREEN][MAX_NUM_VERTICES];
  logic [SW-1:0]                r_psides [MAX_POLYGONS_ON_SCREEN];
  logic [3:0]                   r_pcolors [MAX_POLYGONS_ON_SCREEN];
  logic [CW-1:0]                r_pcount;
  logic                         r_povf;
  logic signed [WORLD_BITS-1:0] r_pcam_x, r_pcam_y;
  logic                         r_overrun;

  // Data on the bus belongs to vertex r_vert-1 while fetching
  logic [SW-1:0] w_vm1;
  logic [VW-1:0] w_vidx;
  logic [SLW-1:0] w_slot;
  logic w_ret, w_bb_clr, w_bb_en, w_room;
  logic signed [WORLD_BITS-1:0] w_minx, w_maxx, w_miny, w_maxy;
  logic signed [WORLD_BITS:0]   w_minx_e, w_maxx_e, w_miny_e, w_maxy_e, w_cx_e, w_cy_e;
  logic w_sides_ok, w_visible;

  assign w_vm1    = r_vert - SW'(1);
  assign w_vidx   = w_vm1[VW-1:0];
  assign w_slot   = r_wcount[SLW-1:0];
  assign w_ret    = (r_state == S_FETCH) && (r_vert != '0);
  assign w_bb_clr = (r_state == S_FETCH) && (r_vert == '0);
  assign w_bb_en  = w_ret && (w_vm1 < world_sides_in);
  assign w_room   = r_wcount < c_SLOTS;

  bbox_accum #(.WORLD_BITS(WORLD_BITS)) u_bbox_x (
    .clk_in(clk_in), .rst_in(rst_in), .i_clear(w_bb_clr), .i_en(w_bb_en),
    .i_val(world_x_in), .o_min(w_minx), .o_max(w_maxx)
  );

  bbox_accum #(.WORLD_BITS(WORLD_BITS)) u_bbox_y (
    .clk_in(clk_in), .rst_in(rst_in), .i_clear(w_bb_clr), .i_en(w_bb_en),
    .i_val(world_y_in), .o_min(w_miny), .o_max(w_maxy)
  );

  // One extra bit so camera +/- reach never wraps near the coordinate limits
  assign w_minx_e = {w_minx[WORLD_BITS-1], w_minx};
  assign w_maxx_e = {w_maxx[WORLD_BITS-1], w_maxx};
  assign w_miny_e = {w_miny[WORLD_BITS-1], w_miny};
  assign w_maxy_e = {w_maxy[WORLD_BITS-1], w_maxy};
  assign w_cx_e   = {r_cam_x[WORLD_BITS-1], r_cam_x};
  assign w_cy_e   = {r_cam_y[WORLD_BITS-1], r_cam_y};

  assign w_sides_ok = (world_sides_in >= SW'(3)) && (world_sides_in <= c_LAST_VERT);
  assign w_visible  = w_sides_ok
                   && (w_maxx_e >= w_cx_e - c_XREACH) && (w_minx_e <= w_cx_e + c_XREACH)
                   && (w_maxy_e >= w_cy_e - c_YREACH) && (w_miny_e <= w_cy_e + c_YREACH);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_busy = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_busy = 1'b1;
        if (r_vert == c_LAST_VERT) w_next = S_CHECK;
      end
      S_CHECK: begin
        w_busy = 1'b1;
        w_next = S_NEXT;
      end
      S_NEXT: begin
        w_busy = 1'b1;
        w_next = (r_poly == c_LAST_POLY) ? S_DONE : S_FETCH;
      end
      S_IDLE, S_DONE: w_next = r_state;
      default:        w_next = S_IDLE;
    endcase
    if (new_frame_in) w_next = S_FETCH;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_poly    <= '0;
      r_vert    <= '0;
      r_cam_x   <= '0;
      r_cam_y   <= '0;
      r_wxs     <= '{default: '0};
      r_wys     <= '{default: '0};
      r_wsides  <= '{default: '0};
      r_wcolors <= '{default: '0};
      r_wcount  <= '0;
      r_wovf    <= 1'b0;
      r_pxs     <= '{default: '0};
      r_pys     <= '{default: '0};
      r_psides  <= '{default: '0};
      r_pcolors <= '{default: '0};
      r_pcount  <= '0;
      r_povf    <= 1'b0;
      r_pcam_x  <= '0;
      r_pcam_y  <= '0;
      r_overrun <= 1'b0;
    end else if (new_frame_in) begin
      if (r_state == S_DONE) begin
        r_pxs     <= r_wxs;
        r_pys     <= r_wys;
        r_psides  <= r_wsides;
        r_pcolors <= r_wcolors;
        r_pcount  <= r_wcount;
        r_povf    <= r_wovf;
        r_pcam_x  <= r_cam_x;
        r_pcam_y  <= r_cam_y;
      end
      // A frame during a scan keeps the old published set and restarts
      if (w_busy) r_overrun <= 1'b1;
      r_cam_x  <= camera_x_in;
      r_cam_y  <= camera_y_in;
      r_wcount <= '0;
      r_wovf   <= 1'b0;
      r_poly   <= '0;
      r_vert   <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          // Vertices land in the next free slot; it is only claimed in CHECK
          if (w_ret && w_room) begin
            r_wxs[w_slot][w_vidx] <= world_x_in;
            r_wys[w_slot][w_vidx] <= world_y_in;
          end
          r_vert <= (r_vert == c_LAST_VERT) ? '0 : r_vert + SW'(1);
        end
        S_CHECK: begin
          if (w_visible) begin
            if (w_room) begin
              r_wsides[w_slot]  <= world_sides_in;
              r_wcolors[w_slot] <= world_color_in;
              r_wcount          <= r_wcount + CW'(1);
            end else begin
              r_wovf <= 1'b1;
            end
          end
        end
        S_NEXT: begin
          if (r_poly != c_LAST_POLY) r_poly <= r_poly + PW'(1);
        end
        default: ;
      endcase
    end
  end

  assign world_poly_out         = r_poly;
  assign world_vert_out         = r_vert[VW-1:0];
  assign camera_x_out           = r_pcam_x;
  assign camera_y_out           = r_pcam_y;
  assign polygons_xs_out        = r_pxs;
  assign polygons_ys_out        = r_pys;
  assign polygons_num_sides_out = r_psides;
  assign colors_out             = r_pcolors;
  assign num_polygons_out       = r_pcount;
  assign overflow_out           = r_povf;
  assign overrun_out            = r_overrun;
  assign busy_out               = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_scene_culler.sv
`default_nettype none
// ============================================================================
// Module      : tb_scene_culler
// Description : Self-checking bench for scene_culler. A world store model
//               answers reads with one cycle of latency; expected on-screen
//               sets come from a bounding-box model over the world arrays.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scene_culler;
  import render_pkg::*;

  localparam int WB = 32;
  localparam int NV = 8;
  localparam int NS = 4;
  localparam int NW = 16;
  localparam int HW = 640;
  localparam int HH = 360;
  localparam int MG = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic nf  = 1'b0;
  logic signed [WB-1:0] cam_x = '0, cam_y = '0;
  logic [3:0] wpoly;
  logic [2:0] wvert;
  logic signed [WB-1:0] wxi, wyi;
  logic [3:0] wsi, wci;
  logic signed [WB-1:0] cxo, cyo;
  logic signed [WB-1:0] pxs [NS][NV];
  logic signed [WB-1:0] pys [NS][NV];
  logic [3:0] psides [NS];
  logic [3:0] pcol [NS];
  logic [2:0] npoly;
  logic ovf, ovr, busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  scene_culler dut (
    .clk_in(clk), .rst_in(rst), .new_frame_in(nf),
    .camera_x_in(cam_x), .camera_y_in(cam_y),
    .world_poly_out(wpoly), .world_vert_out(wvert),
    .world_x_in(wxi), .world_y_in(wyi),
    .world_sides_in(wsi), .world_color_in(wci),
    .camera_x_out(cxo), .camera_y_out(cyo),
    .polygons_xs_out(pxs), .polygons_ys_out(pys),
    .polygons_num_sides_out(psides), .colors_out(pcol),
    .num_polygons_out(npoly), .overflow_out(ovf),
    .overrun_out(ovr), .busy_out(busy)
  );

  // World store with one cycle read latency
  logic signed [WB-1:0] wx [NW][NV];
  logic signed [WB-1:0] wy [NW][NV];
  logic [3:0] wsides [NW];
  logic [3:0] wcol [NW];

  always @(posedge clk) begin
    wxi <= wx[wpoly][wvert];
    wyi <= wy[wpoly][wvert];
    wsi <= wsides[wpoly];
    wci <= wcol[wpoly];
  end

  // Reference expectations
  int exp_n;
  bit exp_ovf;
  int exp_idx [NS];

  function automatic void model(input longint cx, input longint cy);
    exp_n = 0;
    exp_ovf = 1'b0;
    for (int p = 0; p < NW; p++) begin
      int s = int'(wsides[p]);
      longint mnx, mxx, mny, mxy;
      bit vis;
      if (s < 3 || s > NV) continue;
      mnx = wx[p][0]; mxx = wx[p][0]; mny = wy[p][0]; mxy = wy[p][0];
      for (int v = 1; v < s; v++) begin
        if (wx[p][v] < mnx) mnx = wx[p][v];
        if (wx[p][v] > mxx) mxx = wx[p][v];
        if (wy[p][v] < mny) mny = wy[p][v];
        if (wy[p][v] > mxy) mxy = wy[p][v];
      end
      vis = (mxx >= cx - HW - MG) && (mnx <= cx + HW + MG) &&
            (mxy >= cy - HH - MG) && (mny <= cy + HH + MG);
      if (vis) begin
        if (exp_n < NS) begin
          exp_idx[exp_n] = p;
          exp_n++;
        end else begin
          exp_ovf = 1'b1;
        end
      end
    end
  endfunction

  // Number of published fields that disagree with the world polygons the model kept
  function automatic int pub_mismatch();
    int m = 0;
    for (int k = 0; k < exp_n; k++) begin
      int p = exp_idx[k];
      if (psides[k] !== wsides[p]) m++;
      if (pcol[k] !== wcol[p]) m++;
      for (int v = 0; v < int'(wsides[p]); v++) begin
        if (pxs[k][v] !== wx[p][v]) m++;
        if (pys[k][v] !== wy[p][v]) m++;
      end
    end
    return m;
  endfunction

  task automatic clear_world();
    for (int p = 0; p < NW; p++) begin
      wsides[p] = 4'd0;
      wcol[p]   = 4'd0;
      for (int v = 0; v < NV; v++) begin
        // Far-out junk: any vertex beyond the side count leaking into the box shows up
        wx[p][v] = (v % 2 == 1) ? 32'sd1000000000 : -32'sd1000000000;
        wy[p][v] = (v % 2 == 1) ? -32'sd1000000000 : 32'sd1000000000;
      end
    end
  endtask

  task automatic set_rect(input int p, input logic [3:0] c, input int x0, input int x1,
                          input int y0, input int y1);
    wsides[p] = 4'd4;
    wcol[p]   = c;
    wx[p][0] = x0; wy[p][0] = y0;
    wx[p][1] = x1; wy[p][1] = y0;
    wx[p][2] = x1; wy[p][2] = y1;
    wx[p][3] = x0; wy[p][3] = y1;
  endtask

  task automatic pulse(input int x, input int y);
    @(negedge clk);
    cam_x = x;
    cam_y = y;
    nf = 1'b1;
    @(negedge clk);
    nf = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    int n = 0;
    while (busy === 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    ok = (busy === 1'b0);
  endtask

  // Scan with camera (x,y), then publish it; a fresh scan keeps running afterwards
  task automatic frame(input int x, input int y, output bit ok);
    bit ok1, ok2;
    wait_idle(ok1);
    pulse(x, y);
    wait_idle(ok2);
    pulse(x, y);
    ok = ok1 && ok2;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++; if (npoly !== 3'd0) $display("FAIL reset_num: got %0d want 0", npoly); else n_pass++;
    n_checks++; if (ovf !== 1'b0) $display("FAIL reset_ovf: got %0b want 0", ovf); else n_pass++;
    n_checks++; if (ovr !== 1'b0) $display("FAIL reset_ovr: got %0b want 0", ovr); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else n_pass++;
    n_checks++; if (cxo !== 32'sd0 || pcol[0] !== 4'd0) $display("FAIL reset_cam_col: got %0d/%0d want 0/0", cxo, pcol[0]); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    bit ok;
    clear_world();
    set_rect(0, RED, 100, 200, 100, 200);
    wsides[1] = 4'd3; wcol[1] = GREEN;
    wx[1][0] = 300; wx[1][1] = 400; wx[1][2] = 500;
    wy[1][0] = 100; wy[1][1] = 300; wy[1][2] = 100;
    wsides[2] = 4'd5; wcol[2] = YELLOW;
    wx[2][0] = 800; wx[2][1] = 900; wx[2][2] = 870; wx[2][3] = 730; wx[2][4] = 700;
    wy[2][0] = 100; wy[2][1] = 200; wy[2][2] = 300; wy[2][3] = 300; wy[2][4] = 200;
    wait_idle(ok);
    pulse(640, 360);
    n_checks++; if (busy !== 1'b1) $display("FAIL basic_busy: got %0b want 1", busy); else n_pass++;
    frame(640, 360, ok);
    model(640, 360);
    n_checks++; if (!ok) $display("FAIL basic_timeout: got busy want idle"); else n_pass++;
    n_checks++; if (npoly !== 3'd3) $display("FAIL basic_num: got %0d want 3", npoly); else n_pass++;
    n_checks++; if (pcol[0] !== RED || pcol[1] !== GREEN || pcol[2] !== YELLOW)
      $display("FAIL basic_colors: got %0d,%0d,%0d want %0d,%0d,%0d", pcol[0], pcol[1], pcol[2], RED, GREEN, YELLOW);
    else n_pass++;
    n_checks++; if (ovf !== 1'b0) $display("FAIL basic_ovf: got %0b want 0", ovf); else n_pass++;
    n_checks++; if (pub_mismatch() !== 0) $display("FAIL basic_contents: got %0d bad fields want 0", pub_mismatch()); else n_pass++;
    n_checks++; if (cxo !== 32'sd640 || cyo !== 32'sd360) $display("FAIL basic_cam: got %0d,%0d want 640,360", cxo, cyo); else n_pass++;
  endtask

  task automatic test_cull();
    int tcx  [10] = '{640, 1800, 640, 640, 640, 640, 640, 640, 2147483000, -2147483000};
    int tx0  [10] = '{2000, 2000, 1296, 1297, -116, -117, 100, 100, 2147483500, -2147483600};
    int ty0  [10] = '{100, 100, 100, 100, 100, 100, 736, 737, 100, 100};
    int keep [10] = '{0, 1, 1, 0, 1, 0, 1, 0, 1, 1};
    bit ok;
    for (int i = 0; i < 10; i++) begin
      clear_world();
      set_rect(0, BLUE, tx0[i], tx0[i] + 100, ty0[i], ty0[i] + 100);
      frame(tcx[i], 360, ok);
      model(tcx[i], 360);
      n_checks++; if (!ok) $display("FAIL cull_timeout[%0d]: got busy want idle", i); else n_pass++;
      n_checks++; if (npoly !== 3'(keep[i])) $display("FAIL cull_num[%0d]: got %0d want %0d", i, npoly, keep[i]); else n_pass++;
      n_checks++; if (pub_mismatch() !== 0) $display("FAIL cull_contents[%0d]: got %0d bad fields want 0", i, pub_mismatch()); else n_pass++;
    end
  endtask

  task automatic test_overflow();
    bit ok;
    clear_world();
    for (int p = 0; p < 6; p++) set_rect(p, 4'(p + 1), 100 * p, 100 * p + 50, 200, 260);
    frame(640, 360, ok);
    model(640, 360);
    n_checks++; if (npoly !== 3'd4) $display("FAIL ovf_num: got %0d want 4", npoly); else n_pass++;
    n_checks++; if (ovf !== 1'b1) $display("FAIL ovf_flag: got %0b want 1", ovf); else n_pass++;
    n_checks++; if (pcol[3] !== 4'd4) $display("FAIL ovf_slot3_color: got %0d want 4", pcol[3]); else n_pass++;
    n_checks++; if (pub_mismatch() !== 0) $display("FAIL ovf_contents: got %0d bad fields want 0", pub_mismatch()); else n_pass++;
    clear_world();
    set_rect(4, CYAN, 0, 50, 0, 50);
    set_rect(9, PINK, 500, 550, 0, 50);
    frame(640, 360, ok);
    model(640, 360);
    n_checks++; if (npoly !== 3'd2 || ovf !== 1'b0) $display("FAIL ovf_clear: got num %0d ovf %0b want 2/0", npoly, ovf); else n_pass++;
    n_checks++; if (pub_mismatch() !== 0) $display("FAIL ovf_clear_contents: got %0d bad fields want 0", pub_mismatch()); else n_pass++;
  endtask

  task automatic test_bad_sides();
    bit ok;
    clear_world();
    set_rect(0, RED, 100, 200, 100, 200);
    wsides[0] = 4'd2;
    wsides[1] = 4'd9; wcol[1] = GREEN;
    for (int v = 0; v < NV; v++) begin wx[1][v] = 300 + 10 * v; wy[1][v] = 300 + 5 * v; end
    set_rect(2, ORANGE, 400, 450, 400, 450);
    set_rect(3, WHITE, 500, 550, 100, 150);
    wsides[3] = 4'd2;
    frame(640, 360, ok);
    model(640, 360);
    n_checks++; if (npoly !== 3'd1) $display("FAIL sides_num: got %0d want 1", npoly); else n_pass++;
    n_checks++; if (pcol[0] !== ORANGE) $display("FAIL sides_color: got %0d want %0d", pcol[0], ORANGE); else n_pass++;
    n_checks++; if (pub_mismatch() !== 0) $display("FAIL sides_contents: got %0d bad fields want 0", pub_mismatch()); else n_pass++;
  endtask

  task automatic test_random();
    bit ok;
    for (int it = 0; it < 8; it++) begin
      int cx = int'($urandom_range(0, 200000)) - 100000;
      int cy = int'($urandom_range(0, 200000)) - 100000;
      for (int p = 0; p < NW; p++) begin
        int px = cx + int'($urandom_range(0, 4400)) - 2200;
        int py = cy + int'($urandom_range(0, 3000)) - 1500;
        wsides[p] = 4'($urandom_range(0, 9));
        wcol[p]   = 4'($urandom_range(0, 15));
        for (int v = 0; v < NV; v++) begin
          wx[p][v] = px + int'($urandom_range(0, 800)) - 400;
          wy[p][v] = py + int'($urandom_range(0, 800)) - 400;
        end
      end
      frame(cx, cy, ok);
      model(cx, cy);
      n_checks++; if (!ok) $display("FAIL rand_timeout[%0d]: got busy want idle", it); else n_pass++;
      n_checks++; if (npoly !== 3'(exp_n) || ovf !== exp_ovf)
        $display("FAIL rand_num_ovf[%0d]: got %0d/%0b want %0d/%0b", it, npoly, ovf, exp_n, exp_ovf);
      else n_pass++;
      n_checks++; if (pub_mismatch() !== 0) $display("FAIL rand_contents[%0d]: got %0d bad fields want 0", it, pub_mismatch()); else n_pass++;
      n_checks++; if (cxo !== cx || cyo !== cy) $display("FAIL rand_cam[%0d]: got %0d,%0d want %0d,%0d", it, cxo, cyo, cx, cy); else n_pass++;
    end
  endtask

  task automatic test_overrun();
    bit ok;
    clear_world();
    set_rect(0, RED, 100, 200, 100, 200);
    set_rect(1, GREEN, 2000, 2100, 100, 200);
    frame(640, 360, ok);
    wait_idle(ok);
    pulse(640, 360);
    model(640, 360);
    repeat (20) @(negedge clk);
    n_checks++; if (busy !== 1'b1) $display("FAIL overrun_busy_before: got %0b want 1", busy); else n_pass++;
    n_checks++; if (ovr !== 1'b0) $display("FAIL overrun_before: got %0b want 0", ovr); else n_pass++;
    pulse(2000, 360);
    n_checks++; if (ovr !== 1'b1) $display("FAIL overrun_flag: got %0b want 1", ovr); else n_pass++;
    n_checks++; if (npoly !== 3'(exp_n) || cxo !== 32'sd640)
      $display("FAIL overrun_kept: got num %0d cam %0d want %0d/640", npoly, cxo, exp_n);
    else n_pass++;
    n_checks++; if (pub_mismatch() !== 0) $display("FAIL overrun_kept_contents: got %0d bad fields want 0", pub_mismatch()); else n_pass++;
    wait_idle(ok);
    pulse(0, 0);
    model(2000, 360);
    n_checks++; if (!ok) $display("FAIL overrun_timeout: got busy want idle"); else n_pass++;
    n_checks++; if (npoly !== 3'(exp_n) || cxo !== 32'sd2000 || pcol[0] !== GREEN)
      $display("FAIL overrun_next: got num %0d cam %0d col %0d want %0d/2000/%0d", npoly, cxo, pcol[0], exp_n, GREEN);
    else n_pass++;
    n_checks++; if (ovr !== 1'b1) $display("FAIL overrun_sticky: got %0b want 1", ovr); else n_pass++;
  endtask

  task automatic test_reset_midscan();
    bit ok;
    wait_idle(ok);
    pulse(640, 360);
    model(0, 0);
    n_checks++; if (npoly !== 3'(exp_n) || npoly === 3'd0) $display("FAIL rstmid_pre_num: got %0d want %0d", npoly, exp_n); else n_pass++;
    repeat (5) @(negedge clk);
    n_checks++; if (busy !== 1'b1) $display("FAIL rstmid_busy_pre: got %0b want 1", busy); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %0b want 0", busy); else n_pass++;
    n_checks++; if (npoly !== 3'd0 || ovr !== 1'b0 || ovf !== 1'b0)
      $display("FAIL rstmid_flags: got num %0d ovr %0b ovf %0b want 0/0/0", npoly, ovr, ovf);
    else n_pass++;
    n_checks++; if (cxo !== 32'sd0 || pcol[0] !== 4'd0 || wpoly !== 4'd0)
      $display("FAIL rstmid_outs: got cam %0d col %0d poly %0d want 0/0/0", cxo, pcol[0], wpoly);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    clear_world();
    set_rect(3, MAGENTA, 600, 700, 300, 400);
    set_rect(7, LBLUE, -50, 10, -30, 20);
    frame(640, 360, ok);
    model(640, 360);
    n_checks++; if (npoly !== 3'(exp_n) || ovr !== 1'b0)
      $display("FAIL rstmid_after: got num %0d ovr %0b want %0d/0", npoly, ovr, exp_n);
    else n_pass++;
    n_checks++; if (pub_mismatch() !== 0) $display("FAIL rstmid_contents: got %0d bad fields want 0", pub_mismatch()); else n_pass++;
  endtask

  initial begin
    clear_world();
    test_reset();
    test_basic();
    test_cull();
    test_overflow();
    test_bad_sides();
    test_random();
    test_overrun();
    test_reset_midscan();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
